// File: rtl/uart_host_sched_pkg.sv
// Shared types and constants for the UART host-bus scheduler.
package uart_host_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WR_STROBE = 2'b01,
        RD_STROBE = 2'b10,
        GUARD     = 2'b11
    } sched_state_t;

    // Requester index width (NUM_REQ is at most 8)
    localparam int unsigned IDX_W   = 3;
    // Guard counter width (GUARD_CYCLES is at most 7)
    localparam int unsigned GUARD_W = 3;
    // Timeout counter width (TIMEOUT is at most 255)
    localparam int unsigned TMO_W   = 8;

    // Index following idx, wrapping at n
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                  input int unsigned n);
        int unsigned tmp;
        tmp = 32'(idx) + 32'd1;
        if (tmp >= n) begin
            return '0;
        end
        return IDX_W'(tmp);
    endfunction

endpackage

// File: rtl/uart_host_sched_if.sv
// Byte-level host bus between the scheduler and the UART core.
interface uart_host_sched_if;

    logic       uart_csn;
    logic       uart_wen;
    logic       uart_oen;
    logic [7:0] uart_data_in;
    logic       uart_txrdy;
    logic       uart_rxrdy;
    logic [7:0] uart_data_out;
    logic       uart_parity_err;
    logic       uart_framing_err;

    modport master (
        output uart_csn, uart_wen, uart_oen, uart_data_in,
        input  uart_txrdy, uart_rxrdy, uart_data_out,
        input  uart_parity_err, uart_framing_err
    );

    modport slave (
        input  uart_csn, uart_wen, uart_oen, uart_data_in,
        output uart_txrdy, uart_rxrdy, uart_data_out,
        output uart_parity_err, uart_framing_err
    );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module uart_rr_arbiter
    import uart_host_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               found
);

    logic [NUM_REQ-1:0] rot;
    int unsigned        sum;

    // Rotate valid so bit 0 is the pointer position, then take the first set bit
    always_comb begin
        rot        = NUM_REQ'({valid, valid} >> ptr);
        found      = 1'b0;
        winner_idx = '0;
        winner     = '0;
        sum        = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = 32'(ptr) + i;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                winner_idx = IDX_W'(sum);
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            winner[k] = found && (winner_idx == IDX_W'(k));
        end
    end

endmodule

// File: rtl/uart_host_sched.sv
// UART host-bus scheduler: message-granular round-robin transmit arbitration,
// receive drain with priority, guard interval after every strobe, owner timeout.
module uart_host_sched
    import uart_host_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 abort,
    output logic [2:0]           abort_id,
    uart_host_sched_if.master    uart,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_framing_err
);

    sched_state_t       state;
    sched_state_t       state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner_idx;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] sel_oh;
    logic               win_any;
    logic               locked;
    logic               last_q;
    logic               owner_valid;
    logic               read_go;
    logic               write_go;
    logic               timeout_hit;
    logic               sel_last;
    logic [7:0]         sel_data;
    logic [GUARD_W-1:0] guard_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               csn_q;
    logic               wen_q;
    logic               oen_q;
    logic [7:0]         data_in_q;

    uart_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .valid      (req_valid),
        .ptr        (ptr),
        .winner     (win_oh),
        .winner_idx (win_idx),
        .found      (win_any)
    );

    // IDLE decisions: read first, then the locked owner, then a fresh winner
    always_comb begin
        owner_valid = |(req_valid & grant);
        sel_oh      = locked ? grant : win_oh;
        read_go     = (state == IDLE) && uart.uart_rxrdy;
        write_go    = (state == IDLE) && !uart.uart_rxrdy && uart.uart_txrdy &&
                      (locked ? owner_valid : win_any);
        req_ready   = write_go ? (sel_oh & req_valid) : '0;
        timeout_hit = (state == IDLE) && locked && !owner_valid &&
                      (tmo_cnt == TMO_W'(TIMEOUT - 1));
        sel_last    = |(req_last & sel_oh);
        sel_data    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (sel_oh[k]) begin
                sel_data = req_data[8*k +: 8];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (read_go) begin
                    state_next = RD_STROBE;
                end else if (write_go) begin
                    state_next = WR_STROBE;
                end
            end
            WR_STROBE: state_next = GUARD;
            RD_STROBE: state_next = GUARD;
            GUARD: begin
                if (guard_cnt == GUARD_W'(GUARD_CYCLES - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Guard interval counter, cleared outside GUARD
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            guard_cnt <= '0;
        end else if (state == GUARD) begin
            guard_cnt <= guard_cnt + 1'b1;
        end else begin
            guard_cnt <= '0;
        end
    end

    // Ownership, round-robin pointer and timeout release
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            locked    <= 1'b0;
            grant     <= '0;
            owner_idx <= '0;
            ptr       <= '0;
            last_q    <= 1'b0;
            tmo_cnt   <= '0;
            abort     <= 1'b0;
            abort_id  <= '0;
        end else begin
            abort <= 1'b0;
            if (write_go) begin
                last_q  <= sel_last;
                tmo_cnt <= '0;
                if (!locked) begin
                    locked    <= 1'b1;
                    grant     <= win_oh;
                    owner_idx <= win_idx;
                end
            end else if (timeout_hit) begin
                locked   <= 1'b0;
                grant    <= '0;
                ptr      <= next_idx(owner_idx, NUM_REQ);
                abort    <= 1'b1;
                abort_id <= owner_idx;
                tmo_cnt  <= '0;
            end else if ((state == IDLE) && locked && !owner_valid) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            // Release once the final byte of the message has been strobed
            if ((state == WR_STROBE) && last_q) begin
                locked <= 1'b0;
                grant  <= '0;
                ptr    <= next_idx(owner_idx, NUM_REQ);
            end
        end
    end

    // Registered UART strobes, asserted exactly while in a strobe state
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            csn_q     <= 1'b1;
            wen_q     <= 1'b1;
            oen_q     <= 1'b1;
            data_in_q <= '0;
        end else begin
            csn_q <= !((state_next == WR_STROBE) || (state_next == RD_STROBE));
            wen_q <= !(state_next == WR_STROBE);
            oen_q <= !(state_next == RD_STROBE);
            if (write_go) begin
                data_in_q <= sel_data;
            end
        end
    end

    assign uart.uart_csn     = csn_q;
    assign uart.uart_wen     = wen_q;
    assign uart.uart_oen     = oen_q;
    assign uart.uart_data_in = data_in_q;

    // Receive capture at the end of the read strobe; valid pulses the next cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rx_parity_err  <= 1'b0;
            rx_framing_err <= 1'b0;
        end else begin
            rx_valid <= (state == RD_STROBE);
            if (state == RD_STROBE) begin
                rx_data        <= uart.uart_data_out;
                rx_parity_err  <= uart.uart_parity_err;
                rx_framing_err <= uart.uart_framing_err;
            end
        end
    end

endmodule

// File: tb/tb_uart_host_sched.sv
// Self-checking bench for uart_host_sched: table of single-decision vectors
// plus hand-written multi-cycle sequences.
module tb_uart_host_sched;

    localparam int NREQ = 4;
    localparam int GC   = 2;
    localparam int TMO  = 16;

    logic            CLK;
    logic            RESET_N;
    logic [3:0]      req_valid;
    logic [31:0]     req_data;
    logic [3:0]      req_last;
    logic [3:0]      req_ready;
    logic [3:0]      grant;
    logic            abort;
    logic [2:0]      abort_id;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_parity_err;
    logic            rx_framing_err;

    uart_host_sched_if u_if();

    uart_host_sched #(
        .NUM_REQ      (NREQ),
        .GUARD_CYCLES (GC),
        .TIMEOUT      (TMO)
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .grant          (grant),
        .abort          (abort),
        .abort_id       (abort_id),
        .uart           (u_if),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_parity_err  (rx_parity_err),
        .rx_framing_err (rx_framing_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Passive monitor, sampled on the falling edge
    int         cyc = 0;
    logic [3:0] gnt_hist [4096];
    int         wr_n = 0;
    logic [7:0] wr_data [64];
    int         wr_cyc [64];
    int         wr_own [64];
    int         rd_n = 0;
    int         rd_cyc [64];
    int         rx_n = 0;
    int         rx_cyc [64];
    logic [7:0] rx_d [64];
    logic       rx_pe [64];
    logic       rx_fe [64];
    int         ab_n = 0;
    int         ab_cyc [64];
    logic [2:0] ab_id [64];

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (cyc < 4095) gnt_hist[cyc + 1] <= grant;
        if (!u_if.uart_wen && wr_n < 64) begin
            wr_data[wr_n] <= u_if.uart_data_in;
            wr_cyc[wr_n]  <= cyc + 1;
            wr_own[wr_n]  <= oh2idx(grant);
            wr_n          <= wr_n + 1;
        end
        if (!u_if.uart_oen && rd_n < 64) begin
            rd_cyc[rd_n] <= cyc + 1;
            rd_n         <= rd_n + 1;
        end
        if (rx_valid && rx_n < 64) begin
            rx_cyc[rx_n] <= cyc + 1;
            rx_d[rx_n]   <= rx_data;
            rx_pe[rx_n]  <= rx_parity_err;
            rx_fe[rx_n]  <= rx_framing_err;
            rx_n         <= rx_n + 1;
        end
        if (abort && ab_n < 64) begin
            ab_cyc[ab_n] <= cyc + 1;
            ab_id[ab_n]  <= abort_id;
            ab_n         <= ab_n + 1;
        end
    end

    // Requester model: per-requester byte lists, advanced on req_ready
    logic [7:0] m_data [4][8];
    logic       m_last [4][8];
    int         m_len  [4];
    int         m_pos  [4];
    bit         m_loop [4];

    task automatic clear_msgs();
        for (int i = 0; i < 4; i++) begin
            m_len[i]  = 0;
            m_pos[i]  = 0;
            m_loop[i] = 1'b0;
        end
    endtask

    task automatic load(input int r, input int k, input logic [7:0] d, input logic l);
        m_data[r][k] = d;
        m_last[r][k] = l;
        if (k + 1 > m_len[r]) m_len[r] = k + 1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            if (m_pos[i] < m_len[i]) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = m_data[i][m_pos[i]];
                req_last[i]        = m_last[i][m_pos[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // One clock: drive at negedge+1, sample ready, clock, return at next negedge+1
    task automatic step();
        logic [3:0] rdy;
        drive_reqs();
        #1;
        rdy = req_ready;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (rdy[i]) begin
                m_pos[i]++;
                if (m_loop[i] && m_pos[i] >= m_len[i]) m_pos[i] = 0;
            end
        end
        @(negedge CLK);
        #1;
    endtask

    task automatic run_until_writes(input int target, input int budget, input string name);
        for (int k = 0; k < budget && wr_n < target; k++) step();
        chk(name, wr_n, target);
    endtask

    task automatic reset_dut();
        RESET_N = 1'b0;
        clear_msgs();
        req_valid              = '0;
        req_data               = '0;
        req_last               = '0;
        u_if.uart_txrdy        = 1'b0;
        u_if.uart_rxrdy        = 1'b0;
        u_if.uart_data_out     = 8'h00;
        u_if.uart_parity_err   = 1'b0;
        u_if.uart_framing_err  = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    typedef struct {
        logic       rxrdy;
        logic       txrdy;
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic [2:0] exp_strb;   // {csn, wen, oen}
        logic [3:0] exp_grant;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, ab0, rd0, rx0, c1;
        int exp_own [8];
        logic [7:0] exp_dat [8];

        vecs[0] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 3'b111, 4'b0000, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 3'b111, 4'b0000, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 4'b0101, 4'b0000, 3'b111, 4'b0000, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 4'b0100, 4'b0100, 3'b001, 4'b0100, 8'hA2};
        vecs[4] = '{1'b0, 1'b1, 4'b1010, 4'b0010, 3'b001, 4'b0010, 8'hA1};
        vecs[5] = '{1'b0, 1'b1, 4'b1111, 4'b0001, 3'b001, 4'b0001, 8'hA0};
        vecs[6] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 3'b010, 4'b0000, 8'h00};
        vecs[7] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 3'b010, 4'b0000, 8'h00};
        vecs[8] = '{1'b0, 1'b1, 4'b1000, 4'b1000, 3'b001, 4'b1000, 8'hA3};

        // Reset state
        reset_dut();
        chk("rst_csn", u_if.uart_csn, 1);
        chk("rst_wen", u_if.uart_wen, 1);
        chk("rst_oen", u_if.uart_oen, 1);
        chk("rst_data_in", u_if.uart_data_in, 0);
        chk("rst_grant", grant, 0);
        chk("rst_abort", abort, 0);
        chk("rst_abort_id", abort_id, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_errs", {rx_parity_err, rx_framing_err}, 0);
        chk("rst_ready", req_ready, 0);

        // Single IDLE decisions from reset (pointer 0, unlocked)
        for (int i = 0; i < 9; i++) begin
            reset_dut();
            u_if.uart_rxrdy = vecs[i].rxrdy;
            u_if.uart_txrdy = vecs[i].txrdy;
            req_valid       = vecs[i].valid;
            req_data        = 32'hA3A2A1A0;
            req_last        = 4'b1111;
            #1;
            chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].exp_ready);
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_csn", i), u_if.uart_csn, vecs[i].exp_strb[2]);
            chk($sformatf("vec%0d_wen", i), u_if.uart_wen, vecs[i].exp_strb[1]);
            chk($sformatf("vec%0d_oen", i), u_if.uart_oen, vecs[i].exp_strb[0]);
            chk($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
            chk($sformatf("vec%0d_data", i), u_if.uart_data_in, vecs[i].exp_data);
        end

        // 1: three-byte message from requester 0, strobes GC+2 apart
        reset_dut();
        load(0, 0, 8'h11, 1'b0);
        load(0, 1, 8'h22, 1'b0);
        load(0, 2, 8'h33, 1'b1);
        u_if.uart_txrdy = 1'b1;
        b = wr_n;
        run_until_writes(b + 3, 40, "t1_count");
        step();
        step();
        chk("t1_d0", wr_data[b], 8'h11);
        chk("t1_d1", wr_data[b+1], 8'h22);
        chk("t1_d2", wr_data[b+2], 8'h33);
        chk("t1_gap01", wr_cyc[b+1] - wr_cyc[b], GC + 2);
        chk("t1_gap12", wr_cyc[b+2] - wr_cyc[b+1], GC + 2);
        chk("t1_own", wr_own[b+2], 0);
        chk("t1_gnt_at_last", gnt_hist[wr_cyc[b+2]], 4'b0001);
        chk("t1_gnt_after", gnt_hist[wr_cyc[b+2] + 1], 4'b0000);

        // 2: requesters 0 and 2 continuously offering 2-byte messages
        reset_dut();
        load(0, 0, 8'h01, 1'b0);
        load(0, 1, 8'h02, 1'b1);
        load(2, 0, 8'h21, 1'b0);
        load(2, 1, 8'h22, 1'b1);
        m_loop[0] = 1'b1;
        m_loop[2] = 1'b1;
        u_if.uart_txrdy = 1'b1;
        exp_own = '{0, 0, 2, 2, 0, 0, 2, 2};
        exp_dat = '{8'h01, 8'h02, 8'h21, 8'h22, 8'h01, 8'h02, 8'h21, 8'h22};
        b = wr_n;
        run_until_writes(b + 8, 100, "t2_count");
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t2_own%0d", k), wr_own[b+k], exp_own[k]);
            chk($sformatf("t2_data%0d", k), wr_data[b+k], exp_dat[k]);
        end

        // 3: read beats write; errors captured with the byte
        reset_dut();
        load(0, 0, 8'h77, 1'b1);
        u_if.uart_txrdy       = 1'b1;
        u_if.uart_rxrdy       = 1'b1;
        u_if.uart_data_out    = 8'h5A;
        u_if.uart_parity_err  = 1'b1;
        u_if.uart_framing_err = 1'b0;
        b   = wr_n;
        rd0 = rd_n;
        rx0 = rx_n;
        step();
        u_if.uart_rxrdy = 1'b0;
        chk("t3_first_is_read", {u_if.uart_csn, u_if.uart_wen, u_if.uart_oen}, 3'b010);
        run_until_writes(b + 1, 10, "t3_wr_count");
        step();
        chk("t3_rd_count", rd_n - rd0, 1);
        chk("t3_rd_to_wr", wr_cyc[b] - rd_cyc[rd0], GC + 2);
        chk("t3_wr_data", wr_data[b], 8'h77);
        chk("t3_rx_count", rx_n - rx0, 1);
        chk("t3_rx_cycle", rx_cyc[rx0] - rd_cyc[rd0], 1);
        chk("t3_rx_data", rx_d[rx0], 8'h5A);
        chk("t3_rx_perr", rx_pe[rx0], 1);
        chk("t3_rx_ferr", rx_fe[rx0], 0);

        // 4: owner waiting on txrdy=0 neither strobes nor times out
        reset_dut();
        load(1, 0, 8'h41, 1'b0);
        load(1, 1, 8'h42, 1'b1);
        u_if.uart_txrdy = 1'b1;
        b   = wr_n;
        ab0 = ab_n;
        run_until_writes(b + 1, 10, "t4_first");
        u_if.uart_txrdy = 1'b0;
        repeat (40) step();
        chk("t4_no_wr", wr_n - b, 1);
        chk("t4_no_abort", ab_n - ab0, 0);
        chk("t4_grant_held", grant, 4'b0010);
        u_if.uart_txrdy = 1'b1;
        step();
        chk("t4_wen", u_if.uart_wen, 0);
        chk("t4_data", u_if.uart_data_in, 8'h42);

        // 5: owner 1 stalls mid-message, requester 3 waiting
        reset_dut();
        load(1, 0, 8'h51, 1'b0);
        load(3, 0, 8'h71, 1'b1);
        u_if.uart_txrdy = 1'b1;
        b   = wr_n;
        ab0 = ab_n;
        run_until_writes(b + 1, 10, "t5_first");
        c1 = wr_cyc[b];
        repeat (30) step();
        chk("t5_own1", wr_own[b], 1);
        chk("t5_data1", wr_data[b], 8'h51);
        chk("t5_abort_count", ab_n - ab0, 1);
        chk("t5_abort_cycle", ab_cyc[ab0] - c1, 1 + GC + TMO);
        chk("t5_abort_id", ab_id[ab0], 1);
        chk("t5_wr_count", wr_n - b, 2);
        chk("t5_own2", wr_own[b+1], 3);
        chk("t5_data2", wr_data[b+1], 8'h71);
        chk("t5_wr2_cycle", wr_cyc[b+1] - ab_cyc[ab0], 1);

        // 6: reset during GUARD mid-message; pointer restarts at 0
        reset_dut();
        load(2, 0, 8'h81, 1'b1);
        u_if.uart_txrdy = 1'b1;
        b   = wr_n;
        ab0 = ab_n;
        run_until_writes(b + 1, 10, "t6_first");
        repeat (4) step();
        load(1, 0, 8'h91, 1'b0);
        load(1, 1, 8'h92, 1'b0);
        load(1, 2, 8'h93, 1'b1);
        run_until_writes(b + 2, 10, "t6_second");
        step();
        chk("t6_pre_data", u_if.uart_data_in, 8'h91);
        chk("t6_pre_grant", grant, 4'b0010);
        RESET_N = 1'b0;
        #1;
        chk("t6_rst_csn", u_if.uart_csn, 1);
        chk("t6_rst_wen", u_if.uart_wen, 1);
        chk("t6_rst_oen", u_if.uart_oen, 1);
        chk("t6_rst_data", u_if.uart_data_in, 0);
        chk("t6_rst_grant", grant, 0);
        reset_dut();
        load(0, 0, 8'hC0, 1'b1);
        load(3, 0, 8'hC3, 1'b1);
        u_if.uart_txrdy = 1'b1;
        run_until_writes(b + 3, 10, "t6_after");
        chk("t6_own", wr_own[b+2], 0);
        chk("t6_data", wr_data[b+2], 8'hC0);
        chk("t6_no_abort", ab_n - ab0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
